// File: rtl/and_gate_pkg.sv
// Shared defaults for the AND gate block.
// Operand width and counter width live here.
package and_gate_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/and_gate_sat_cnt.sv
// Saturating up-counter with sync clear and async reset.
// Holds at all-ones instead of wrapping.
module and_gate_sat_cnt
  import and_gate_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic at_max;

  assign at_max = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/and_gate.sv
// Bitwise AND with registered copy and built-in result checker.
// Checker tallies matches and mismatches against exp_y.
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  input  logic             en,
  output logic [WIDTH-1:0] Y_q,
  input  logic             chk_en,
  input  logic [WIDTH-1:0] exp_y,
  input  logic             clr,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic             mismatch
);

  logic pass_inc;
  logic fail_inc;

  assign Y = A & B;

  // Case inequality so X/Z on either side flags a mismatch.
  assign mismatch = chk_en && (Y !== exp_y);

  assign pass_inc = chk_en && !mismatch;
  assign fail_inc = mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_q <= '0;
    end else if (en) begin
      Y_q <= Y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (fail_inc) begin
      err <= 1'b1;
    end
  end

  and_gate_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_pass_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(pass_inc),
    .cnt(pass_cnt)
  );

  and_gate_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_fail_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(fail_inc),
    .cnt(fail_cnt)
  );

endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: stimulus queues expectations,
// a monitor process pops and compares against the DUT.
module tb_and_gate;

  logic        clk;
  logic        rst;
  logic [0:0]  A, B, Y, Y_q, exp_y;
  logic        en, chk_en, clr;
  logic [15:0] pass_cnt, fail_cnt;
  logic        err, mismatch;
  logic [0:0]  Y2, Y_q2;
  logic [1:0]  pass_cnt2, fail_cnt2;
  logic        err2, mismatch2;

  typedef enum int {
    S_Y, S_YQ, S_PASS, S_FAIL, S_ERR, S_MIS, S_PASS2, S_FAIL2
  } sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   passed = 0;
  int   total  = 0;

  and_gate #(.WIDTH(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Y(Y),
    .en(en), .Y_q(Y_q), .chk_en(chk_en), .exp_y(exp_y),
    .clr(clr), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err(err), .mismatch(mismatch)
  );

  and_gate #(.WIDTH(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Y(Y2),
    .en(en), .Y_q(Y_q2), .chk_en(chk_en), .exp_y(exp_y),
    .clr(clr), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
    .err(err2), .mismatch(mismatch2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(sig_e s);
    case (s)
      S_Y:     return {31'd0, Y};
      S_YQ:    return {31'd0, Y_q};
      S_PASS:  return {16'd0, pass_cnt};
      S_FAIL:  return {16'd0, fail_cnt};
      S_ERR:   return {31'd0, err};
      S_MIS:   return {31'd0, mismatch};
      S_PASS2: return {30'd0, pass_cnt2};
      S_FAIL2: return {30'd0, fail_cnt2};
      default: return 'x;
    endcase
  endfunction

  // Monitor: drains the scoreboard at each sample point.
  initial begin
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] a;
        e = sb.pop_front();
        a = actual(e.sig);
        total++;
        if (a === e.val) passed++;
        else $display("FAIL %s: got %0h expected %0h", e.name, a, e.val);
      end
    end
  end

  task automatic expect_val(string name, sig_e s, logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sig  = s;
    e.val  = v;
    sb.push_back(e);
    ->sample_ev;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] vec [4];
  logic [0:0] and_exp [4];

  initial begin
    vec[0] = 2'b00; and_exp[0] = 1'b0;
    vec[1] = 2'b01; and_exp[1] = 1'b0;
    vec[2] = 2'b10; and_exp[2] = 1'b0;
    vec[3] = 2'b11; and_exp[3] = 1'b1;

    rst = 1'b1; clr = 1'b0; en = 1'b0; chk_en = 1'b0;
    A = 1'b1; B = 1'b1; exp_y = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_val("rst_yq", S_YQ, 0);
    expect_val("rst_pass", S_PASS, 0);
    expect_val("rst_fail", S_FAIL, 0);
    expect_val("rst_err", S_ERR, 0);
    expect_val("rst_y_live", S_Y, 1);

    @(negedge clk);
    rst = 1'b0;

    // Truth table, combinational only
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {A, B} = vec[i];
      #1;
      expect_val($sformatf("tt_y%0d", i), S_Y, and_exp[i]);
      expect_val($sformatf("tt_mis%0d", i), S_MIS, 0);
    end

    // Matching checks
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {A, B} = vec[i];
      chk_en = 1'b1;
      exp_y = and_exp[i];
      #1;
      expect_val($sformatf("pass_mis%0d", i), S_MIS, 0);
    end
    @(negedge clk);
    chk_en = 1'b0;
    #1;
    expect_val("pass_cnt4", S_PASS, 4);
    expect_val("pass_fail0", S_FAIL, 0);
    expect_val("pass_err0", S_ERR, 0);
    expect_val("pass2_sat3", S_PASS2, 3);

    // Mismatching checks
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {A, B} = vec[i];
      chk_en = 1'b1;
      exp_y = ~and_exp[i];
      #1;
      expect_val($sformatf("fail_mis%0d", i), S_MIS, 1);
      edge_settle();
      expect_val($sformatf("fail_cnt%0d", i), S_FAIL, i + 1);
      expect_val($sformatf("fail_err%0d", i), S_ERR, 1);
    end
    expect_val("fail2_sat3", S_FAIL2, 3);
    expect_val("fail_pass_hold", S_PASS, 4);

    // Fifth failure: wide counter moves, narrow one holds
    edge_settle();
    expect_val("fail_cnt5", S_FAIL, 5);
    expect_val("fail2_hold3", S_FAIL2, 3);
    @(negedge clk);
    chk_en = 1'b0;
    #1;
    expect_val("chk_off_mis", S_MIS, 0);
    edge_settle();
    expect_val("chk_off_fail", S_FAIL, 5);

    // Registered copy
    @(negedge clk);
    A = 1'b1; B = 1'b1; en = 1'b1;
    edge_settle();
    expect_val("yq_load", S_YQ, 1);
    @(negedge clk);
    en = 1'b0; A = 1'b0;
    edge_settle();
    expect_val("yq_hold", S_YQ, 1);
    expect_val("yq_y0", S_Y, 0);

    // Async reset between edges, with a pending failing check
    @(negedge clk);
    A = 1'b1; B = 1'b1;
    chk_en = 1'b1; exp_y = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    expect_val("arst_yq", S_YQ, 0);
    expect_val("arst_pass", S_PASS, 0);
    expect_val("arst_fail", S_FAIL, 0);
    expect_val("arst_err", S_ERR, 0);
    expect_val("arst_fail2", S_FAIL2, 0);
    expect_val("arst_mis_live", S_MIS, 1);
    edge_settle();
    expect_val("arst_discard", S_FAIL, 0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    edge_settle();
    expect_val("post_rst_fail", S_FAIL, 1);
    expect_val("post_rst_err", S_ERR, 1);
    expect_val("post_rst_yq", S_YQ, 1);

    // Clear wins over a simultaneous failing check
    @(negedge clk);
    en = 1'b0;
    clr = 1'b1;
    edge_settle();
    expect_val("clr_fail", S_FAIL, 0);
    expect_val("clr_pass", S_PASS, 0);
    expect_val("clr_err", S_ERR, 0);
    expect_val("clr_yq", S_YQ, 1);
    @(negedge clk);
    clr = 1'b0;
    chk_en = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) #1;
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      total++;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
